// File: rtl/vga_pkg.sv
// Shared timing constants, colour width and update-FSM encoding for the VGA display controller.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int CNT_W    = 10;
  localparam int RGB_W    = 12;
  localparam int N_LAYERS = 4;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } upd_state_e;

endpackage

// File: rtl/vga_layer_mux.sv
// Two-stage fixed-priority layer mux with a matching sync/DE delay line.
// Stage 1 captures the inputs, stage 2 resolves the colour, so every output lags the counts by two clocks.
module vga_layer_mux #(
  parameter int              N_LAYERS = vga_pkg::N_LAYERS,
  parameter int              RGB_W    = vga_pkg::RGB_W,
  parameter logic [RGB_W-1:0] BG_RGB  = '0
) (
  input  logic                      pxl_clk,
  input  logic                      reset,
  input  logic                      active,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [N_LAYERS-1:0]       layer_valid,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      de_out
);

  logic                      active_d, active_q;
  logic                      hs1_d, hs1_q, vs1_d, vs1_q;
  logic [N_LAYERS-1:0]       valid_d, valid_q;
  logic [N_LAYERS*RGB_W-1:0] lrgb_d, lrgb_q;

  logic [RGB_W-1:0]          rgb_d, rgb_q;
  logic                      de_d, de_q;
  logic                      hs2_d, hs2_q, vs2_d, vs2_q;
  logic [RGB_W-1:0]          pix_rgb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pix_rgb = BG_RGB;
    // Walk from the lowest priority upward so the lowest valid index is written last and wins.
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (valid_q[i]) pix_rgb = lrgb_q[i*RGB_W +: RGB_W];
    end

    active_d = active;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
    valid_d  = layer_valid;
    lrgb_d   = layer_rgb;

    rgb_d    = active_q ? pix_rgb : '0;
    de_d     = active_q;
    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      // Syncs are active-low, so their idle reset value is 1.
      active_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      valid_q  <= '0;
      lrgb_q   <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      active_q <= active_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      valid_q  <= valid_d;
      lrgb_q   <= lrgb_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  assign rgb_out   = rgb_q;
  assign de_out    = de_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display scheduler: layer arbitration on the pixel path and one game-logic update window per
// frame, opened at the first vertical-blank line and closed by upd_ack or the frame wrap.
module vga_display_ctrl #(
  parameter int               N_LAYERS = vga_pkg::N_LAYERS,
  parameter int               RGB_W    = vga_pkg::RGB_W,
  parameter int               H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int               V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter logic [RGB_W-1:0] BG_RGB   = '0
) (
  input  logic                      pxl_clk,
  input  logic                      reset,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [N_LAYERS-1:0]       layer_valid,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic                      upd_ack,
  output logic                      upd_req,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      de_out,
  output logic                      frame_start,
  output logic [7:0]                missed_cnt
);

  import vga_pkg::*;

  logic       active;
  logic       wrap;
  logic       blank_entry;
  logic       miss;

  upd_state_e state_d, state_q;
  logic       upd_req_d, upd_req_q;
  logic       frame_start_d, frame_start_q;
  logic [7:0] missed_d, missed_q;

  assign active      = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign wrap        = (hcount == 10'd0) && (vcount == 10'd0);
  assign blank_entry = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

  vga_layer_mux #(
    .N_LAYERS (N_LAYERS),
    .RGB_W    (RGB_W),
    .BG_RGB   (BG_RGB)
  ) u_layer_mux (
    .pxl_clk     (pxl_clk),
    .reset       (reset),
    .active      (active),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .layer_valid (layer_valid),
    .layer_rgb   (layer_rgb),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de_out      (de_out)
  );

  always_comb begin
    state_d = state_q;
    miss    = 1'b0;
    unique case (state_q)
      SCAN: if (blank_entry) state_d = SCAN == SCAN ? REQ : SCAN;
      REQ: begin
        // An ack in the wrap cycle still counts as served.
        if (upd_ack) begin
          state_d = DONE;
        end else if (wrap) begin
          state_d = SCAN;
          miss    = 1'b1;
        end
      end
      DONE:    if (wrap) state_d = SCAN;
      default: state_d = SCAN;
    endcase

    upd_req_d     = (state_d == REQ);
    frame_start_d = wrap;
    missed_d      = (miss && (missed_q != 8'hFF)) ? missed_q + 8'd1 : missed_q;
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      state_q       <= SCAN;
      upd_req_q     <= 1'b0;
      frame_start_q <= 1'b0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      upd_req_q     <= upd_req_d;
      frame_start_q <= frame_start_d;
      missed_q      <= missed_d;
    end
  end

  assign upd_req     = upd_req_q;
  assign frame_start = frame_start_q;
  assign missed_cnt  = missed_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl: pixel latency/priority, update window, misses and frame pulses.
module tb_vga_display_ctrl;

  localparam int               NL = 4;
  localparam int               RW = 12;
  localparam logic [RW-1:0]    BG = 12'h123;

  logic             pxl_clk = 1'b0;
  logic             reset;
  logic [9:0]       hcount, vcount;
  logic             hsync_in, vsync_in;
  logic [NL-1:0]    layer_valid;
  logic [NL*RW-1:0] layer_rgb;
  logic             upd_ack;
  logic             upd_req;
  logic [RW-1:0]    rgb_out;
  logic             hsync_out, vsync_out, de_out, frame_start;
  logic [7:0]       missed_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  vga_display_ctrl #(
    .N_LAYERS (NL),
    .RGB_W    (RW),
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .BG_RGB   (BG)
  ) dut (
    .pxl_clk     (pxl_clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .layer_valid (layer_valid),
    .layer_rgb   (layer_rgb),
    .upd_ack     (upd_ack),
    .upd_req     (upd_req),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de_out      (de_out),
    .frame_start (frame_start),
    .missed_cnt  (missed_cnt)
  );

  always #5 pxl_clk = ~pxl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge pxl_clk);
    #1;
  endtask

  task automatic set_pos(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
  endtask

  task automatic step(input int h, input int v);
    set_pos(h, v);
    tick();
  endtask

  int fh[10] = '{0, 1, 639, 640, 799, 0,   0,   0, 100, 799};
  int fv[10] = '{0, 0, 0,   0,   0,   1, 479, 480, 490, 524};

  initial begin
    int pulses;
    int misaligned;

    reset       = 1'b1;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    layer_valid = '0;
    layer_rgb   = '0;
    upd_ack     = 1'b0;
    set_pos(700, 10);
    tick();
    tick();
    reset = 1'b0;

    // Build up non-reset state: one missed frame, open window, visible pixel, syncs low.
    step(0, 480);
    step(0, 0);
    step(0, 480);
    set_pos(100, 50);
    layer_valid = 4'b0001;
    layer_rgb   = {12'h000, 12'h000, 12'h000, 12'hABC};
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    tick();
    tick();
    check("pre_reset_rgb", 32'(rgb_out), 32'h0ABC);
    check("pre_reset_req", 32'(upd_req), 32'd1);
    check("pre_reset_missed", 32'(missed_cnt), 32'd1);

    // Test 1: reset mid-frame.
    reset = 1'b1;
    tick();
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_de", 32'(de_out), 32'd0);
    check("rst_hsync", 32'(hsync_out), 32'd1);
    check("rst_vsync", 32'(vsync_out), 32'd1);
    check("rst_req", 32'(upd_req), 32'd0);
    check("rst_missed", 32'(missed_cnt), 32'd0);
    check("rst_fstart", 32'(frame_start), 32'd0);
    reset    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    // Reset landed mid-blank: no window until the next blank-line entry.
    step(0, 490);
    step(5, 490);
    check("mid_blank_no_req", 32'(upd_req), 32'd0);
    step(0, 0);
    check("wrap_fstart", 32'(frame_start), 32'd1);

    // Test 2: latency and priority.
    layer_valid = 4'b1111;
    step(700, 10);
    step(700, 10);
    set_pos(100, 50);
    layer_valid = 4'b0110;
    layer_rgb   = {12'h00F, 12'h0F0, 12'hF00, 12'hFFF};
    hsync_in    = 1'b0;
    tick();
    check("lat1_de", 32'(de_out), 32'd0);
    check("lat1_hsync", 32'(hsync_out), 32'd1);
    hsync_in = 1'b1;
    tick();
    check("prio_rgb", 32'(rgb_out), 32'h0F00);
    check("prio_de", 32'(de_out), 32'd1);
    check("lat2_hsync", 32'(hsync_out), 32'd0);
    tick();
    check("hsync_release", 32'(hsync_out), 32'd1);

    layer_valid = 4'b1100;
    step(639, 479);
    tick();
    check("prio_l2_corner", 32'(rgb_out), 32'h00F0);

    // Test 3: blanking forces 0, empty active pixel shows background.
    layer_valid = 4'b1111;
    step(700, 10);
    tick();
    check("hblank_rgb", 32'(rgb_out), 32'h0);
    check("hblank_de", 32'(de_out), 32'd0);
    layer_valid = 4'b0000;
    step(10, 10);
    tick();
    check("bg_rgb", 32'(rgb_out), 32'(BG));
    check("bg_de", 32'(de_out), 32'd1);
    layer_valid = 4'b1000;
    vsync_in    = 1'b0;
    step(10, 480);
    tick();
    check("vblank_rgb", 32'(rgb_out), 32'h0);
    check("vblank_vsync", 32'(vsync_out), 32'd0);
    vsync_in    = 1'b1;
    layer_valid = 4'b0000;

    // Test 4: update window open/close.
    step(0, 0);
    step(0, 479);
    check("req_before_blank", 32'(upd_req), 32'd0);
    step(0, 480);
    check("req_rise", 32'(upd_req), 32'd1);
    step(0, 485);
    check("req_hold", 32'(upd_req), 32'd1);
    upd_ack = 1'b1;
    step(0, 490);
    upd_ack = 1'b0;
    check("req_fall_ack", 32'(upd_req), 32'd0);
    step(0, 480);
    check("done_no_rearm", 32'(upd_req), 32'd0);
    step(0, 0);
    check("done_wrap_fstart", 32'(frame_start), 32'd1);
    check("acked_no_miss", 32'(missed_cnt), 32'd0);
    step(1, 0);
    check("fstart_one_cycle", 32'(frame_start), 32'd0);

    // Test 5: unacknowledged frames and ack coincident with wrap.
    for (int i = 0; i < 3; i++) begin
      step(0, 480);
      check("miss_req_rise", 32'(upd_req), 32'd1);
      step(0, 0);
      check("miss_req_fall", 32'(upd_req), 32'd0);
    end
    check("missed_3", 32'(missed_cnt), 32'd3);
    step(0, 480);
    upd_ack = 1'b1;
    step(0, 0);
    upd_ack = 1'b0;
    check("ack_wins_missed", 32'(missed_cnt), 32'd3);
    check("ack_wins_req", 32'(upd_req), 32'd0);

    // Saturation at 255.
    step(0, 0);
    for (int i = 0; i < 260; i++) begin
      step(0, 480);
      step(0, 0);
      if (i == 250) check("missed_254", 32'(missed_cnt), 32'd254);
      if (i == 251) check("missed_255", 32'(missed_cnt), 32'd255);
    end
    check("missed_sat", 32'(missed_cnt), 32'd255);

    // Test 6: two compressed frames give exactly two aligned frame_start pulses.
    pulses     = 0;
    misaligned = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10; k++) begin
        step(fh[k], fv[k]);
        if (frame_start) begin
          pulses++;
          if (!(fh[k] == 0 && fv[k] == 0)) misaligned++;
        end
      end
    end
    check("frame_pulses", 32'(pulses), 32'd2);
    check("pulse_alignment", 32'(misaligned), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
